bram_rd_stream: RTL and testbench

//   Read-side engine for the asymmetric dual-port block RAM: 16-bit writes on port A, 32-bit reads on port B.
//   On a start command it issues sequential port-B reads (enb/addrb) and captures doutb.
//   It emits each 32-bit word as OUT_W-bit halves, low half first, on a valid/ready stream.
//   It sits between the BRAM read port and any downstream consumer of 16-bit samples.
//

---
 rtl/bram_rd_stream.sv | 139 +++++++++++++
 tb/tb_bram_rd_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_stream.sv
// bram_rd_stream
//   Read-side engine for an asymmetric dual-port BRAM. On start it issues
//   sequential port-B reads, captures doutb into a 2-entry word buffer and
//   streams every word out as two OUT_W halves, low half first.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 command pulse (ignored while busy)
//     base_addr, num_words  transfer parameters, sampled with start
//     busy, done            transfer status / 1-cycle completion pulse
//     enb, addrb, doutb     BRAM port-B read interface
//     m_data, m_valid,
//     m_ready               output half-word stream
//     m_last                final half of the transfer (BRAM_RD_LAST_EN only)
//
//   Optional feature macro: BRAM_RD_LAST_EN adds the m_last output.
module bram_rd_stream #(
   parameter int RD_ADDR_W = 1,
   parameter int RD_DATA_W = 32,
   parameter int OUT_W     = 16,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [RD_ADDR_W-1:0] base_addr,
   input  logic [RD_ADDR_W:0]   num_words,
   output logic                 busy,
   output logic                 done,
   output logic                 enb,
   output logic [RD_ADDR_W-1:0] addrb,
   input  logic [RD_DATA_W-1:0] doutb,
   output logic [OUT_W-1:0]     m_data,
   output logic                 m_valid,
   input  logic                 m_ready
`ifdef BRAM_RD_LAST_EN
   ,
   output logic                 m_last
`endif
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [RD_ADDR_W-1:0]   addr_q, addr_d;
   logic [RD_ADDR_W:0]     left_q, left_d;
   logic                   done_q, done_d;
   logic [RD_LAT-1:0]      pipe_q, pipe_d;     // one bit per in-flight read
   logic [RD_DATA_W-1:0]   buf_q [2];
   logic                   wr_q, rd_q, half_q;
   logic [1:0]             cnt_q, cnt_d;       // buffered words
   logic [1:0]             infl;
   logic                   push, pop;
   logic [RD_LAT:0]        pipe_ext;

   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LAT; i++) infl = infl + 2'(pipe_q[i]);
   end

   assign push    = pipe_q[RD_LAT-1];
   assign m_valid = (cnt_q != 2'd0);
   assign pop     = m_valid & m_ready & half_q;   // word leaves after its high half

   // Credit: a new read may start only if buffered + in-flight words, less
   // the word retiring this cycle, stay below the buffer depth.
   assign enb = (state_q == READ) &&
                (({1'b0, cnt_q} + {1'b0, infl}) < (3'd2 + 3'(pop)));

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign addrb  = addr_q;
   assign m_data = !m_valid ? '0 :
                   half_q   ? buf_q[rd_q][RD_DATA_W-1:OUT_W] : buf_q[rd_q][OUT_W-1:0];

`ifdef BRAM_RD_LAST_EN
   // Only the final word can be buffered with nothing in flight while draining.
   assign m_last = m_valid && half_q && (state_q == DRAIN) && (cnt_q == 2'd1) && (infl == 2'd0);
`endif

   assign pipe_ext = {pipe_q, enb};
   assign pipe_d   = pipe_ext[RD_LAT-1:0];
   assign cnt_d    = cnt_q + 2'(push) - 2'(pop);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      left_d  = left_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            addr_d = base_addr;
            left_d = num_words;
            if (num_words != '0) state_d = READ;
            else                 done_d  = 1'b1;
         end
         READ: if (enb) begin
            addr_d = addr_q + 1'b1;   // wraps modulo 2**RD_ADDR_W
            left_d = left_q - 1'b1;
            if (left_q == 1) state_d = DRAIN;
         end
         DRAIN: if (pop && cnt_q == 2'd1 && infl == 2'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         left_q   <= '0;
         done_q   <= 1'b0;
         pipe_q   <= '0;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         half_q   <= 1'b0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         left_q  <= left_d;
         done_q  <= done_d;
         pipe_q  <= pipe_d;
         cnt_q   <= cnt_d;
         if (push) begin
            buf_q[wr_q] <= doutb;
            wr_q        <= ~wr_q;
         end
         if (m_valid && m_ready) half_q <= ~half_q;
         if (pop) rd_q <= ~rd_q;
      end
   end

endmodule

// File: tb/tb_bram_rd_stream.sv
module tb_bram_rd_stream;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [0:0]  base_addr = '0;
   logic [1:0]  num_words = '0;
   logic        busy, done, enb;
   logic [0:0]  addrb;
   logic [31:0] doutb = '0;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
`ifdef BRAM_RD_LAST_EN
   logic        m_last;
`endif

   bram_rd_stream dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_words(num_words), .busy(busy), .done(done), .enb(enb),
      .addrb(addrb), .doutb(doutb), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready)
`ifdef BRAM_RD_LAST_EN
      , .m_last(m_last)
`endif
   );

   always #5 clk = ~clk;

   // BRAM port-B model, latency 1
   logic [31:0] mem [2];
   initial begin mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h1234_5678; end
   always @(posedge clk) if (enb) doutb <= mem[addrb];

   int checks = 0, errors = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Monitor
   logic [15:0] got_q[$], exp_q[$];
   int          adr_q[$], exp_adr[$];
   int          done_cnt = 0, n_enb = 0, n_half = 0, exp_total = 0;
   logic        stall_p = 1'b0;
   logic [15:0] data_p = '0;

   task automatic clr();
      got_q.delete(); adr_q.delete();
      done_cnt = 0; n_enb = 0; n_half = 0;
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst_n) stall_p = 1'b0;
      else begin
         if (stall_p) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(data_p));
         end
         stall_p = m_valid && !m_ready;
         data_p  = m_data;
         if (m_valid && m_ready) begin
`ifdef BRAM_RD_LAST_EN
            chk("m_last", 32'(m_last), 32'(n_half == exp_total - 1));
`endif
            got_q.push_back(m_data);
            n_half++;
         end
         if (enb) begin
            adr_q.push_back(int'(addrb));
            n_enb++;
            chk("credit", 32'((n_enb - n_half / 2) <= 2), 32'd1);
         end
         if (done) begin
            done_cnt++;
            chk("done_busy", 32'(busy), 32'd0);
         end
      end
   end

   // Backpressure pattern 1,0,0,1 repeating
   bit       rdy_tgl = 1'b0;
   bit [3:0] pat = 4'b1001;
   initial begin
      int k = 0;
      forever begin
         @(posedge clk); #1;
         if (rdy_tgl) begin m_ready = pat[k % 4]; k++; end
      end
   end

   task automatic run_xfer(input logic [0:0] b, input logic [1:0] n, input bit poke);
      int k;
      clr();
      exp_total = exp_q.size();
      @(posedge clk); #1; start = 1'b1; base_addr = b; num_words = n;
      @(posedge clk); #1; start = 1'b0;
      k = 0;
      while (done_cnt == 0 && k < 200) begin
         if (poke && k == 1) begin start = 1'b1; base_addr = 1'b1; num_words = 2'd3; end
         else start = 1'b0;
         @(posedge clk); #1; k++;
      end
      start = 1'b0;
      chk("timeout", 32'(k < 200), 32'd1);
      repeat (3) @(posedge clk); #1;
      chk("n_out", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("data%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      chk("n_enb", adr_q.size(), exp_adr.size());
      for (int i = 0; i < exp_adr.size() && i < adr_q.size(); i++)
         chk($sformatf("addr%0d", i), adr_q[i], exp_adr[i]);
      chk("done_cnt", done_cnt, 1);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_busy", 32'(busy), 0);   chk("rst_done", 32'(done), 0);
      chk("rst_enb", 32'(enb), 0);     chk("rst_valid", 32'(m_valid), 0);
      chk("rst_addrb", 32'(addrb), 0); chk("rst_data", 32'(m_data), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Test 1: cycle-accurate, m_ready=1
      clr(); exp_total = 4;
      #1; start = 1'b1; base_addr = 0; num_words = 2;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1; start = 1'b0;
         @(negedge clk);
         case (c)
            1: begin chk("t1_enb1", 32'(enb), 1); chk("t1_busy1", 32'(busy), 1);
                     chk("t1_adr1", 32'(addrb), 0); chk("t1_v1", 32'(m_valid), 0); end
            2: begin chk("t1_enb2", 32'(enb), 1); chk("t1_adr2", 32'(addrb), 1);
                     chk("t1_v2", 32'(m_valid), 0); end
            3: begin chk("t1_v3", 32'(m_valid), 1); chk("t1_d3", 32'(m_data), 32'hBEEF);
                     chk("t1_enb3", 32'(enb), 0); end
            4: chk("t1_d4", 32'(m_data), 32'hDEAD);
            5: chk("t1_d5", 32'(m_data), 32'h5678);
            6: begin chk("t1_d6", 32'(m_data), 32'h1234); chk("t1_done6", 32'(done), 0); end
            7: begin chk("t1_done7", 32'(done), 1); chk("t1_busy7", 32'(busy), 0);
                     chk("t1_v7", 32'(m_valid), 0); end
            default: chk("t1_done8", 32'(done), 0);
         endcase
      end
      chk("t1_nenb", n_enb, 2);

      // Test 2: backpressure
      exp_q = '{16'hBEEF, 16'hDEAD, 16'h5678, 16'h1234};
      exp_adr = '{0, 1};
      rdy_tgl = 1'b1;
      run_xfer(1'b0, 2'd2, 1'b0);
      rdy_tgl = 1'b0; m_ready = 1'b1;

      // Test 3: wrap
      exp_q = '{16'h5678, 16'h1234, 16'hBEEF, 16'hDEAD, 16'h5678, 16'h1234};
      exp_adr = '{1, 0, 1};
      run_xfer(1'b1, 2'd3, 1'b0);

      // Test 4a: num=0
      clr();
      @(posedge clk); #1; start = 1'b1; base_addr = 0; num_words = 0;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("t4_done", 32'(done), 1); chk("t4_enb", 32'(enb), 0);
      chk("t4_valid", 32'(m_valid), 0);
      @(posedge clk); #1;
      chk("t4_done_off", 32'(done), 0);
      repeat (3) @(posedge clk); #1;
      chk("t4_nenb", n_enb, 0); chk("t4_nout", got_q.size(), 0);

      // Test 4b: start while busy is ignored
      exp_q = '{16'hBEEF, 16'hDEAD, 16'h5678, 16'h1234};
      exp_adr = '{0, 1};
      run_xfer(1'b0, 2'd2, 1'b1);

      // Test 5: async reset mid-stream
      clr();
      @(posedge clk); #1; start = 1'b1; base_addr = 0; num_words = 2;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);   // first half handshaken at this edge
      #1; rst_n = 1'b0; #1;
      chk("t5_nhalf", n_half, 1);
      chk("t5_busy", 32'(busy), 0); chk("t5_done", 32'(done), 0);
      chk("t5_enb", 32'(enb), 0);   chk("t5_valid", 32'(m_valid), 0);
      chk("t5_addrb", 32'(addrb), 0); chk("t5_data", 32'(m_data), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      run_xfer(1'b0, 2'd2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
